// File: rtl/gpio_speed_pkg.sv
// Shared definitions for the GPIO speed-test generator and checker.
// Holds the count format and the checker state encoding.
package gpio_speed_pkg;

  localparam int CNT_WIDTH   = 10;
  localparam int CNT_MODULUS = 1000;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

endpackage

// File: rtl/mod_incr.sv
// Combinational modulo incrementer: cur -> next value in the count sequence.
// MODULUS-1 wraps to 0; no implicit wrap at 2^WIDTH.
module mod_incr
  import gpio_speed_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MODULUS = CNT_MODULUS
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // Wrap at the sequence period, otherwise plain increment
  always_comb begin
    nxt = cur + 1'b1;
    if (cur == WIDTH'(MODULUS - 1)) begin
      nxt = '0;
    end
  end

endmodule

// File: rtl/gpio_seq_checker.sv
// GPIO loopback sequence checker: locks onto the modulo count stream
// and keeps saturating good/error statistics while locked.
module gpio_seq_checker
  import gpio_speed_pkg::*;
#(
  parameter int WIDTH         = CNT_WIDTH,
  parameter int MODULUS       = CNT_MODULUS,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] good_count,
  output logic [WIDTH-1:0] last_bad
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int CERR_W = $clog2(UNLOCK_ERRORS + 1);

  chk_state_t        state_q, state_d;
  logic [WIDTH-1:0]  din_q;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  expected;
  logic              match;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [CERR_W-1:0] cerr_q, cerr_d;
  logic [CNT_W-1:0]  good_d, errc_d;
  logic [WIDTH-1:0]  bad_d;
  logic              pulse_d;
  logic              locked_d;

  mod_incr #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_incr (
    .cur(prev_q),
    .nxt(expected)
  );

  assign match = (din_q == expected);

  // Input capture stage; all checking works on din_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) din_q <= '0;
    else        din_q <= din;
  end

  // State and statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      run_q      <= '0;
      cerr_q     <= '0;
      good_count <= '0;
      err_count  <= '0;
      last_bad   <= '0;
      err_pulse  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      cerr_q     <= cerr_d;
      good_count <= good_d;
      err_count  <= errc_d;
      last_bad   <= bad_d;
      err_pulse  <= pulse_d;
      locked     <= locked_d;
    end
  end

  // Next-state, flywheel tracking and statistics update
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    cerr_d  = cerr_q;
    good_d  = good_count;
    errc_d  = err_count;
    bad_d   = last_bad;
    pulse_d = 1'b0;
    unique case (state_q)
      SEARCH: begin
        prev_d  = din_q;
        run_d   = '0;
        state_d = ACQUIRE;
      end
      ACQUIRE: begin
        prev_d = din_q;
        if (match) begin
          if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
            run_d   = '0;
            state_d = LOCKED;
          end else begin
            run_d = run_q + 1'b1;
          end
        end else begin
          run_d = '0;
        end
      end
      LOCKED: begin
        prev_d = expected;
        if (match) begin
          cerr_d = '0;
          if (good_count != '1) begin
            good_d = good_count + 1'b1;
          end
        end else begin
          pulse_d = 1'b1;
          bad_d   = din_q;
          if (err_count != '1) begin
            errc_d = err_count + 1'b1;
          end
          if (cerr_q == CERR_W'(UNLOCK_ERRORS - 1)) begin
            cerr_d  = '0;
            state_d = SEARCH;
          end else begin
            cerr_d = cerr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
    if (clear) begin
      good_d = '0;
      errc_d = '0;
      bad_d  = '0;
    end
    locked_d = (state_d == LOCKED);
  end

endmodule

// File: tb/tb_gpio_seq_checker.sv
// Bench for gpio_seq_checker: directed scenarios plus random stream,
// two instances (default and 4-bit counters with long unlock).
module tb_gpio_seq_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  din;
  logic        clear;

  logic        locked_a, pulse_a;
  logic [15:0] errc_a, good_a;
  logic [9:0]  bad_a;
  logic        locked_b, pulse_b;
  logic [3:0]  errc_b, good_b;
  logic [9:0]  bad_b;

  int checks = 0;
  int errors = 0;
  int np = 0;
  int cur = 0;

  int cmax[2] = '{65535, 15};
  int unl[2]  = '{3, 18};

  bit m_lock[2], m_primed[2], m_pulse[2];
  int m_prev[2], m_run[2], m_cerr[2];
  int m_good[2], m_err[2], m_bad[2];
  int m_dq;

  gpio_seq_checker dut_a (
    .clk(clk), .reset(reset), .din(din), .clear(clear),
    .locked(locked_a), .err_pulse(pulse_a),
    .err_count(errc_a), .good_count(good_a), .last_bad(bad_a)
  );

  gpio_seq_checker #(
    .CNT_W(4), .UNLOCK_ERRORS(18)
  ) dut_b (
    .clk(clk), .reset(reset), .din(din), .clear(clear),
    .locked(locked_b), .err_pulse(pulse_b),
    .err_count(errc_b), .good_count(good_b), .last_bad(bad_b)
  );

  function automatic int nextv(input int p);
    if (p < 1000) return (p + 1) % 1000;
    return (p + 1) % 1024;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = 0; m_primed[k] = 0; m_pulse[k] = 0;
      m_prev[k] = 0; m_run[k] = 0; m_cerr[k] = 0;
      m_good[k] = 0; m_err[k] = 0; m_bad[k] = 0;
    end
    m_dq = 0;
  endtask

  task automatic m_step();
    int e;
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 0;
      if (!m_lock[k]) begin
        if (!m_primed[k]) begin
          m_prev[k] = m_dq; m_run[k] = 0; m_primed[k] = 1;
        end else begin
          e = nextv(m_prev[k]);
          m_prev[k] = m_dq;
          if (m_dq == e) begin
            m_run[k]++;
            if (m_run[k] == 4) begin m_lock[k] = 1; m_run[k] = 0; end
          end else m_run[k] = 0;
        end
      end else begin
        e = nextv(m_prev[k]);
        m_prev[k] = e;
        if (m_dq == e) begin
          m_cerr[k] = 0;
          if (m_good[k] < cmax[k]) m_good[k]++;
        end else begin
          m_pulse[k] = 1;
          m_bad[k] = m_dq;
          if (m_err[k] < cmax[k]) m_err[k]++;
          m_cerr[k]++;
          if (m_cerr[k] == unl[k]) begin
            m_lock[k] = 0; m_primed[k] = 0; m_cerr[k] = 0;
          end
        end
      end
      if (clear) begin m_good[k] = 0; m_err[k] = 0; m_bad[k] = 0; end
    end
    m_dq = int'(din);
  endtask

  task automatic compare_all();
    chk("a.locked", 32'(locked_a), 32'(m_lock[0]));
    chk("a.err_pulse", 32'(pulse_a), 32'(m_pulse[0]));
    chk("a.err_count", 32'(errc_a), m_err[0]);
    chk("a.good_count", 32'(good_a), m_good[0]);
    chk("a.last_bad", 32'(bad_a), m_bad[0]);
    chk("b.locked", 32'(locked_b), 32'(m_lock[1]));
    chk("b.err_pulse", 32'(pulse_b), 32'(m_pulse[1]));
    chk("b.err_count", 32'(errc_b), m_err[1]);
    chk("b.good_count", 32'(good_b), m_good[1]);
    chk("b.last_bad", 32'(bad_b), m_bad[1]);
  endtask

  task automatic cyc(input int v, input bit c);
    din = 10'(v);
    clear = c;
    @(posedge clk);
    if (reset) m_step();
    #1;
    compare_all();
    if (pulse_a === 1'b1) np++;
  endtask

  task automatic stream(input int n);
    repeat (n) begin
      cyc(cur, 0);
      cur = (cur + 1) % 1000;
    end
  endtask

  task automatic lock_wait(input string tag, input int bound);
    int at;
    at = 0;
    for (int i = 1; i <= bound + 2; i++) begin
      cyc(cur, 0);
      cur = (cur + 1) % 1000;
      if (locked_a === 1'b1 && at == 0) at = i;
    end
    chk(tag, 32'(at > 0 && at <= bound), 1);
  endtask

  initial begin
    int snap;
    int lk;
    reset = 1'b0;
    din = '0;
    clear = 1'b0;
    m_reset();
    #1;
    chk("reset.locked", 32'(locked_a), 0);
    chk("reset.good", 32'(good_a), 0);
    repeat (5) cyc(0, 0);
    reset = 1'b1;

    cur = 0;
    lock_wait("clean_lock", 6);
    stream(8);
    chk("clean.good", 32'(good_a), 10);
    chk("clean.err", 32'(errc_a), 0);

    cyc(cur, 1); cur++;
    while (cur != 201) stream(1);
    cur = 600;
    np = 0;
    stream(4);
    chk("jump.pulses", np, 3);
    chk("jump.err", 32'(errc_a), 3);
    chk("jump.unlocked", 32'(locked_a), 0);
    lock_wait("jump.relock", 6);
    stream(10);
    chk("jump.no_more", np, 3);

    while (cur != 998) stream(1);
    snap = m_good[0];
    np = 0;
    stream(5);
    chk("wrap.good_delta", 32'(good_a), snap + 5);
    chk("wrap.pulses", np, 0);

    cyc(cur, 1); cur++;
    while (cur != 437) stream(1);
    np = 0;
    cyc(500, 0);
    chk("glitch.early", 32'(pulse_a), 0);
    cyc(438, 0);
    chk("glitch.pulse", 32'(pulse_a), 1);
    chk("glitch.last_bad", 32'(bad_a), 500);
    cur = 439;
    stream(5);
    chk("glitch.count", np, 1);
    chk("glitch.err", 32'(errc_a), 1);
    chk("glitch.locked", 32'(locked_a), 1);

    cyc(900, 0);
    cyc(901, 1);
    chk("clrmis.pulse", 32'(pulse_a), 1);
    chk("clrmis.err", 32'(errc_a), 0);
    cyc(902, 0);
    chk("clrmis.still", 32'(locked_a), 1);
    cur = (cur + 3) % 1000;
    cyc(cur, 0);
    chk("clrmis.unlock", 32'(locked_a), 0);
    cur = (cur + 1) % 1000;

    stream(12);
    chk("pre_rst.locked", 32'(locked_a), 1);
    #3;
    reset = 1'b0;
    m_reset();
    #1;
    compare_all();
    chk("rst.locked", 32'(locked_a), 0);
    chk("rst.good", 32'(good_a), 0);
    cyc(cur, 0);
    cyc(cur, 0);
    reset = 1'b1;
    cur = 0;
    lock_wait("rst.relock", 6);

    stream(10);
    cyc(cur, 1);
    cur = (cur + 1) % 1000;
    np = 0;
    lk = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1023, 0);
      if (i >= 5 && locked_a !== 1'b0) lk++;
    end
    chk("oor.pulses", np, 3);
    chk("oor.no_lock", lk, 0);
    chk("oor.err", 32'(errc_a), 3);
    chk("sat.err_b", 32'(errc_b), 15);

    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) cyc($urandom_range(0, 1023), ($urandom_range(0, 29) == 0));
      else begin
        if (r < 6) cur = $urandom_range(0, 999);
        cyc(cur, ($urandom_range(0, 29) == 0));
      end
      cur = (cur + 1) % 1000;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_seq_checker.md
Name: gpio_seq_checker

Overview:
Receive-side partner of the GPIO speed-test counter generator. It samples the 10-bit modulo-1000 count stream arriving over the GPIO loopback in the clk domain and locks onto the sequence. It then flags every sample that does not equal the previous value +1 (mod MODULUS) and keeps good/error statistics that software reads to judge link integrity at the tested toggle rate.

Parameters:
WIDTH, 10, data bus width; must match the generator.
MODULUS, 1000, sequence period; the expected value after MODULUS-1 is 0.
LOCK_COUNT, 4, consecutive correct samples required to declare lock.
UNLOCK_ERRORS, 3, consecutive errors while locked that force re-acquisition.
CNT_W, 16, width of good_count and err_count.

Ports:
clk  in  1  sample clock, same clock as the generator.
reset  in  1  asynchronous, active-low.
din  in  WIDTH  count value from the GPIO pins.
clear  in  1  synchronous statistics clear; FSM unaffected.
locked  out  1  high while the FSM is in LOCKED.
err_pulse  out  1  one-cycle pulse per mismatching sample while locked.
err_count  out  CNT_W  saturating mismatch count while locked.
good_count  out  CNT_W  saturating match count while locked.
last_bad  out  WIDTH  din value of the most recent mismatch.

Behaviour:
- Reset is clk, asynchronous, active-low. All registers clear to 0. State = SEARCH; locked=0, err_pulse=0, counts=0, last_bad=0.
- Input stage: din_q <= din every cycle. All checking uses din_q.
- expected = (prev == MODULUS-1) ? 0 : prev+1. The width is WIDTH, so there is no natural wrap at 2^WIDTH. A din_q >= MODULUS never matches.
- match = (din_q == expected).
- FSM:
  SEARCH: prev <= din_q; run <= 0; go to ACQUIRE next cycle.
  ACQUIRE: prev <= din_q. On match, run <= run+1, and when run+1 == LOCK_COUNT go to LOCKED with run <= 0. On mismatch, run <= 0 and stay in ACQUIRE. No statistics are updated in this state.
  LOCKED: flywheel rule, prev <= expected regardless of match, so a single corrupted sample costs exactly one error.
    On match: good_count++ (saturating at all-ones) and cerr <= 0.
    On mismatch: err_pulse=1, err_count++ (saturating), last_bad <= din_q, cerr <= cerr+1. When cerr+1 == UNLOCK_ERRORS, go to SEARCH with cerr <= 0.
- locked and err_pulse are registered outputs.
- Latency: a din value presented before edge n is registered at edge n and evaluated at edge n+1. Its err_pulse and counter update are visible after edge n+1, i.e. 2 cycles of latency.
- A clean stream locks within LOCK_COUNT+2 cycles of the first sample.
- The unlocking error is itself counted (err_pulse=1, err_count++).
- clear:
  - Zeroes err_count, good_count and last_bad on the next edge.
  - When clear coincides with a mismatch, clear wins for the counters (they read 0), but err_pulse still asserts and the FSM still advances.
- Saturation: once a counter reaches all-ones it holds until clear or reset.
- Reset mid-operation: immediate return to reset values; re-acquisition starts from SEARCH.

Decomposition:
- Shared package gpio_speed_pkg holds:
  - CNT_WIDTH=10 and CNT_MODULUS=1000, used by both the generator and this checker.
  - The checker state encoding: SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
- One natural sub-module, mod_incr (combinational prev -> expected modulo-MODULUS incrementer). The generator can reuse it.

Test Plan:
- Clean lock: reset low 5 cycles, then din = 0,1,2,... per cycle -> locked=1 within 6 cycles of the first sample; err_count=0; good_count increments by 1 per cycle.
- Wrap: locked stream passes 997,998,999,0,1 -> no err_pulse; good_count advances by 5 over those samples.
- Single glitch: locked; replace 437 with 500 and continue with 438 -> exactly one err_pulse, 2 cycles after 500 is driven; err_count=1; last_bad=500; locked stays 1.
- Persistent jump: locked; stream goes ...199,200,600,601,602,... -> 3 err_pulses; err_count=3; locked falls after the third; relocks within LOCK_COUNT+2 cycles on 603+; no further errors.
- Out-of-range and saturation (CNT_W=4): locked; drive 1023 for 20 cycles -> unlock after 3 errors and no lock while the value is held. With UNLOCK_ERRORS set to 2^CNT_W+2, 20 consecutive errors -> err_count saturates at 15 and stays there.
- Clear and reset: assert clear in the same cycle as a mismatch -> err_pulse=1, err_count=0 next cycle, FSM cerr still advances. Drop reset while locked -> all outputs 0 immediately; clean relock afterwards.
